// File: rtl/div_bank.sv
// Bank of independent programmable clock dividers on clk_27.
// Each channel has a shadowed divisor that takes effect on its next terminal edge.
module div_bank #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 25,
    parameter int DEF_DIV = 27000,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_27,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  mode,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  slow_clk,
    output logic [N_CH-1:0]  pend
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act;
        logic [CNT_W-1:0] shd;
        logic             pnd;
        logic             md;
        logic             tck;
        logic             slw;
        logic             hit;
        logic             term;

        // Out-of-range selects never match any channel index.
        assign hit  = div_wr && (div_sel == SEL_W'(ch));
        assign term = en[ch] && (cnt == act);

        always_ff @(posedge clk_27 or negedge rst) begin
            if (!rst) begin
                cnt  <= '0;
                act  <= CNT_W'(DEF_DIV);
                shd  <= CNT_W'(DEF_DIV);
                pnd  <= 1'b0;
                md   <= 1'b0;
                tck  <= 1'b0;
                slw  <= 1'b0;
            end else if (!en[ch]) begin
                cnt  <= '0;
                tck  <= 1'b0;
                slw  <= 1'b0;
                md   <= mode[ch];
                if (hit) begin
                    act <= div_val;
                    shd <= div_val;
                    pnd <= 1'b0;
                end else if (pnd) begin
                    act <= shd;
                    pnd <= 1'b0;
                end
            end else if (term) begin
                cnt  <= '0;
                tck  <= 1'b1;
                md   <= mode[ch];
                // Mode is sampled only here so slow_clk never changes shape mid-period.
                slw  <= mode[ch] ? 1'b1 : ~slw;
                if (hit) begin
                    act <= div_val;
                    shd <= div_val;
                    pnd <= 1'b0;
                end else if (pnd) begin
                    act <= shd;
                    pnd <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tck  <= 1'b0;
                if (md) begin
                    slw <= 1'b0;
                end
                if (hit) begin
                    shd <= div_val;
                    pnd <= 1'b1;
                end
            end
        end

        assign tick[ch]     = tck;
        assign slow_clk[ch] = slw;
        assign pend[ch]     = pnd;
    end

endmodule

// File: tb/tb_div_bank.sv
// Randomized and directed bench for div_bank against a period-level reference model.
module tb_div_bank;
    localparam int N_CH = 4;
    localparam int CNT_W = 8;
    localparam int DEF_DIV = 3;

    logic             clk_27 = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  mode;
    logic             div_wr;
    logic [1:0]       div_sel;
    logic [CNT_W-1:0] div_val;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  slow_clk;
    logic [N_CH-1:0]  pend;

    int checks = 0;
    int errors = 0;

    // Reference: period length, position within period, pending divisor.
    int m_act [N_CH];
    int m_shd [N_CH];
    int m_pos [N_CH];
    bit m_pend[N_CH];
    bit m_tick[N_CH];
    bit m_slow[N_CH];
    bit m_md  [N_CH];

    div_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk_27(clk_27), .rst(rst), .en(en), .mode(mode), .div_wr(div_wr),
        .div_sel(div_sel), .div_val(div_val), .tick(tick), .slow_clk(slow_clk), .pend(pend)
    );

    always #5 clk_27 = ~clk_27;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_act[c] = DEF_DIV; m_shd[c] = DEF_DIV; m_pos[c] = 0;
            m_pend[c] = 0; m_tick[c] = 0; m_slow[c] = 0; m_md[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < N_CH; c++) begin
            bit wr;
            wr = div_wr && (int'(div_sel) == c);
            if (!en[c]) begin
                m_pos[c] = 0; m_tick[c] = 0; m_slow[c] = 0; m_md[c] = mode[c];
                if (wr) begin
                    m_act[c] = int'(div_val); m_shd[c] = int'(div_val); m_pend[c] = 0;
                end else if (m_pend[c]) begin
                    m_act[c] = m_shd[c]; m_pend[c] = 0;
                end
            end else begin
                m_pos[c]++;
                if (m_pos[c] == m_act[c] + 1) begin
                    m_pos[c] = 0;
                    m_tick[c] = 1;
                    m_md[c] = mode[c];
                    m_slow[c] = m_md[c] ? 1'b1 : !m_slow[c];
                    if (wr) begin
                        m_act[c] = int'(div_val); m_shd[c] = int'(div_val); m_pend[c] = 0;
                    end else if (m_pend[c]) begin
                        m_act[c] = m_shd[c]; m_pend[c] = 0;
                    end
                end else begin
                    m_tick[c] = 0;
                    if (m_md[c]) m_slow[c] = 0;
                    if (wr) begin
                        m_shd[c] = int'(div_val); m_pend[c] = 1;
                    end
                end
            end
        end
    endfunction

    task automatic compare(input string tag);
        logic [N_CH-1:0] et, es, ep;
        for (int c = 0; c < N_CH; c++) begin
            et[c] = m_tick[c]; es[c] = m_slow[c]; ep[c] = m_pend[c];
        end
        chk({tag, "_tick"}, int'(tick), int'(et));
        chk({tag, "_slow"}, int'(slow_clk), int'(es));
        chk({tag, "_pend"}, int'(pend), int'(ep));
    endtask

    task automatic step(input string tag);
        @(posedge clk_27);
        model_edge();
        #1;
        compare(tag);
        @(negedge clk_27);
        div_wr = 1'b0;
    endtask

    task automatic write(input int sel, input int val);
        div_wr = 1'b1; div_sel = 2'(sel); div_val = CNT_W'(val);
    endtask

    initial begin
        int n;
        rst = 1'b0; en = '0; mode = '0; div_wr = 1'b0; div_sel = '0; div_val = '0;
        model_reset();
        @(negedge clk_27); @(negedge clk_27);
        compare("reset");
        rst = 1'b1;

        // Channel 0 toggle mode at DEF_DIV
        en = 4'b0001;
        for (int i = 0; i < 20; i++) step("basic");

        // Mid-period write of divisor 1
        for (int i = 0; i < 8 && m_pos[0] != 1; i++) step("align1");
        write(0, 1);
        step("wr_mid");
        chk("pend_after_wr", int'(pend[0]), 1);
        for (int i = 0; i < 12; i++) step("div1");
        chk("pend_cleared", int'(pend[0]), 0);

        // Write on the terminal edge: direct load of 0
        for (int i = 0; i < 8 && m_pos[0] != m_act[0]; i++) step("align2");
        write(0, 0);
        step("wr_term");
        chk("pend_direct", int'(pend[0]), 0);
        for (int i = 0; i < 6; i++) begin
            step("div0");
            chk("tick_cont", int'(tick[0]), 1);
        end

        // Disabled write loads at once; first tick after act+1 edges
        en[0] = 1'b0;
        step("dis");
        write(0, 7);
        step("dis_wr");
        chk("pend_dis_wr", int'(pend[0]), 0);
        en[0] = 1'b1;
        n = 0;
        do begin
            step("reen");
            n++;
        end while (!tick[0] && n < 20);
        chk("reen_first_tick", n, 8);

        // Channel 1 pulse mode, then mode change mid-period
        en[1] = 1'b1; mode[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step("pulse");
            chk("pulse_eq", int'(slow_clk[1]), int'(tick[1]));
        end
        for (int i = 0; i < 8 && m_pos[1] != 1; i++) step("align3");
        mode[1] = 1'b0;
        for (int i = 0; i < 14; i++) step("mode_chg");

        // Reset mid-count with a pending divisor
        write(0, 5);
        step("pre_rst");
        chk("pend_pre_rst", int'(pend[0]), 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare("rst_mid");
        @(negedge clk_27);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step("post_rst");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, N_CH-1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) mode[$urandom_range(0, N_CH-1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) write(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
